// File: rtl/rr_mux_stream.sv
// N-channel stream multiplexer with a round-robin arbiter, an optional forced select,
// and a single registered output stage with a valid/ready handshake.
module rr_mux_stream #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      fixed_en,
  input  logic [SEL_W-1:0]          fixed_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_sel_reg;
  logic                out_valid_reg;
  logic [SEL_W-1:0]    rr_ptr_reg;

  logic                load;
  logic [CHANNELS-1:0] upper_mask;
  logic [CHANNELS-1:0] req_upper;
  logic [CHANNELS-1:0] fixed_hit;
  logic [SEL_W-1:0]    lo_all;
  logic [SEL_W-1:0]    lo_upper;
  logic [SEL_W-1:0]    rr_idx;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    grant_data;

  assign load = ~out_valid_reg | out_ready;

  // Channels strictly above the pointer are searched first; if none request, the
  // search wraps to the lowest requester. This is the circular search without adders.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign upper_mask[gi] = (SEL_W'(gi) > rr_ptr_reg);
      assign fixed_hit[gi]  = in_valid[gi] & (fixed_sel == SEL_W'(gi));
      assign in_ready[gi]   = load & grant_any & (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign req_upper = in_valid & upper_mask;

  always_comb begin
    lo_all   = '0;
    lo_upper = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i])  lo_all   = SEL_W'(i);
      if (req_upper[i]) lo_upper = SEL_W'(i);
    end
    rr_idx = (|req_upper) ? lo_upper : lo_all;
  end

  // An out-of-range fixed_sel matches no channel, so fixed_hit stays zero.
  always_comb begin
    if (fixed_en) begin
      grant_any = |fixed_hit;
      grant_idx = fixed_sel;
    end else begin
      grant_any = |in_valid;
      grant_idx = rr_idx;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (grant_any) begin
        out_data_reg  <= grant_data;
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (!fixed_en) rr_ptr_reg <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed and randomized bench for rr_mux_stream: an 8-channel instance for most
// scenarios and a 5-channel instance for the non-power-of-two wrap case.
module tb_rr_mux_stream;

  logic         clock;
  logic         reset;

  logic [127:0] in_data8;
  logic [7:0]   in_valid8;
  logic [7:0]   in_ready8;
  logic         fixed_en8;
  logic [2:0]   fixed_sel8;
  logic [15:0]  out_data8;
  logic [2:0]   out_sel8;
  logic         out_valid8;
  logic         out_ready8;

  logic [79:0]  in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic         fixed_en5;
  logic [2:0]   fixed_sel5;
  logic [15:0]  out_data5;
  logic [2:0]   out_sel5;
  logic         out_valid5;
  logic         out_ready5;

  int checks;
  int failures;

  rr_mux_stream #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) dut8 (
    .clock(clock), .reset(reset),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .fixed_en(fixed_en8), .fixed_sel(fixed_sel8),
    .out_data(out_data8), .out_sel(out_sel8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  rr_mux_stream #(.WIDTH(16), .CHANNELS(5), .SEL_W(3)) dut5 (
    .clock(clock), .reset(reset),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .fixed_en(fixed_en5), .fixed_sel(fixed_sel5),
    .out_data(out_data5), .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid8 !== 1'b0 || out_data8 !== 16'h0 || out_sel8 !== 3'd0) begin
      failures++;
      $display("FAIL reset_state8 got v=%b d=%h s=%0d want v=0 d=0000 s=0", out_valid8, out_data8, out_sel8);
    end
    checks++;
    if (out_valid5 !== 1'b0 || out_data5 !== 16'h0 || out_sel5 !== 3'd0) begin
      failures++;
      $display("FAIL reset_state5 got v=%b d=%h s=%0d want v=0 d=0000 s=0", out_valid5, out_data5, out_sel5);
    end
    reset = 1'b0;
    in_data8[2*16 +: 16] = 16'hABCD;
    in_valid8 = 8'h04;
    out_ready8 = 1'b0;
    tick();
    checks++;
    if (out_valid8 !== 1'b1 || out_data8 !== 16'hABCD || out_sel8 !== 3'd2) begin
      failures++;
      $display("FAIL reset_preload got v=%b d=%h s=%0d want v=1 d=abcd s=2", out_valid8, out_data8, out_sel8);
    end
    in_valid8 = 8'h00;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || out_data8 !== 16'h0 || out_sel8 !== 3'd0) begin
      failures++;
      $display("FAIL reset_async got v=%b d=%h s=%0d want v=0 d=0000 s=0", out_valid8, out_data8, out_sel8);
    end
    $display("test_reset done checks=%0d", checks);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_rr_rotation();
    logic [7:0] exp_rdy;
    for (int i = 0; i < 8; i++) in_data8[i*16 +: 16] = 16'(16'h1000 + i);
    in_valid8 = 8'hFF;
    out_ready8 = 1'b1;
    fixed_en8 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_rdy = 8'h01 << (k % 8);
      checks++;
      if (in_ready8 !== exp_rdy) begin
        failures++;
        $display("FAIL rr_ready k=%0d got %b want %b", k, in_ready8, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== 16'(16'h1000 + (k % 8)) || out_sel8 !== 3'(k % 8)) begin
        failures++;
        $display("FAIL rr_out k=%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                 k, out_valid8, out_data8, out_sel8, 16'(16'h1000 + (k % 8)), k % 8);
      end
      $display("rr k=%0d sel=%0d data=%h", k, out_sel8, out_data8);
    end
  endtask

  task automatic test_backpressure();
    out_ready8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready8 !== 8'h00) begin
        failures++;
        $display("FAIL bp_ready k=%0d got %b want 00000000", k, in_ready8);
      end
      tick();
      checks++;
      if (out_valid8 !== 1'b1 || out_data8 !== 16'h1000 || out_sel8 !== 3'd0) begin
        failures++;
        $display("FAIL bp_hold k=%0d got v=%b d=%h s=%0d want v=1 d=1000 s=0", k, out_valid8, out_data8, out_sel8);
      end
      $display("bp stall k=%0d data=%h", k, out_data8);
    end
    out_ready8 = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 8'h02) begin
      failures++;
      $display("FAIL bp_release_ready got %b want 00000010", in_ready8);
    end
    tick();
    checks++;
    if (out_data8 !== 16'h1001 || out_sel8 !== 3'd1) begin
      failures++;
      $display("FAIL bp_release_out got d=%h s=%0d want d=1001 s=1", out_data8, out_sel8);
    end
    #1;
    checks++;
    if (in_ready8 !== 8'h04) begin
      failures++;
      $display("FAIL bp_next_ready got %b want 00000100", in_ready8);
    end
    tick();
    checks++;
    if (out_sel8 !== 3'd2) begin
      failures++;
      $display("FAIL bp_next_sel got %0d want 2", out_sel8);
    end
    $display("bp released sel=%0d data=%h", out_sel8, out_data8);
  endtask

  task automatic test_fixed();
    fixed_en8 = 1'b1;
    fixed_sel8 = 3'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready8 !== 8'h20) begin
        failures++;
        $display("FAIL fixed_ready k=%0d got %b want 00100000", k, in_ready8);
      end
      tick();
      checks++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'd5 || out_data8 !== 16'h1005) begin
        failures++;
        $display("FAIL fixed_out k=%0d got v=%b d=%h s=%0d want v=1 d=1005 s=5", k, out_valid8, out_data8, out_sel8);
      end
      $display("fixed k=%0d sel=%0d data=%h", k, out_sel8, out_data8);
    end
    fixed_en8 = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 8'h08) begin
      failures++;
      $display("FAIL fixed_resume_ready got %b want 00001000", in_ready8);
    end
    tick();
    checks++;
    if (out_sel8 !== 3'd3 || out_data8 !== 16'h1003) begin
      failures++;
      $display("FAIL fixed_resume_out got d=%h s=%0d want d=1003 s=3", out_data8, out_sel8);
    end
    fixed_en8 = 1'b1;
    in_valid8 = 8'hDF;
    #1;
    checks++;
    if (in_ready8 !== 8'h00) begin
      failures++;
      $display("FAIL fixed_idle_ready got %b want 00000000", in_ready8);
    end
    tick();
    checks++;
    if (out_valid8 !== 1'b0 || out_data8 !== 16'h1003 || out_sel8 !== 3'd3) begin
      failures++;
      $display("FAIL fixed_idle_out got v=%b d=%h s=%0d want v=0 d=1003 s=3", out_valid8, out_data8, out_sel8);
    end
    $display("fixed idle valid=%b", out_valid8);
    fixed_en8 = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid8 = 8'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_ready8 !== 8'h10) begin
        failures++;
        $display("FAIL b2b_ready k=%0d got %b want 00010000", k, in_ready8);
      end
      tick();
      checks++;
      if (out_valid8 !== 1'b1 || out_sel8 !== 3'd4 || out_data8 !== 16'h1004) begin
        failures++;
        $display("FAIL b2b_out k=%0d got v=%b d=%h s=%0d want v=1 d=1004 s=4", k, out_valid8, out_data8, out_sel8);
      end
      $display("b2b k=%0d sel=%0d", k, out_sel8);
    end
    in_valid8 = 8'h00;
    tick();
    checks++;
    if (out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got v=%b want 0", out_valid8);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [2:0] exp_sel;
    for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'(16'h2000 + i);
    in_valid5 = 5'b10001;
    out_ready5 = 1'b1;
    fixed_en5 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_sel = (k % 2 == 0) ? 3'd0 : 3'd4;
      #1;
      checks++;
      if (in_ready5 !== ((k % 2 == 0) ? 5'b00001 : 5'b10000)) begin
        failures++;
        $display("FAIL wrap_ready k=%0d got %b want sel %0d", k, in_ready5, exp_sel);
      end
      tick();
      checks++;
      if (out_valid5 !== 1'b1 || out_sel5 !== exp_sel || out_data5 !== 16'(16'h2000 + exp_sel)) begin
        failures++;
        $display("FAIL wrap_out k=%0d got v=%b d=%h s=%0d want v=1 s=%0d", k, out_valid5, out_data5, out_sel5, exp_sel);
      end
      $display("wrap k=%0d sel=%0d data=%h", k, out_sel5, out_data5);
    end
    fixed_en5 = 1'b1;
    fixed_sel5 = 3'd6;
    #1;
    checks++;
    if (in_ready5 !== 5'b00000) begin
      failures++;
      $display("FAIL oor_ready got %b want 00000", in_ready5);
    end
    tick();
    checks++;
    if (out_valid5 !== 1'b0 || out_data5 !== 16'h2004 || out_sel5 !== 3'd4) begin
      failures++;
      $display("FAIL oor_out got v=%b d=%h s=%0d want v=0 d=2004 s=4", out_valid5, out_data5, out_sel5);
    end
    $display("oor fixed_sel=6 valid=%b", out_valid5);
  endtask

  task automatic test_random();
    logic        pv [8];
    int unsigned seq [8];
    int          wait_cnt [8];
    logic [15:0] sb [$];
    logic [15:0] exp_w;
    int          g;
    int          xfers;
    int          fails_before;
    fails_before = failures;
    xfers = 0;
    #3;
    reset = 1'b1;
    in_valid8 = 8'h00;
    fixed_en8 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      seq[i] = 0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        in_valid8[i] = pv[i];
        in_data8[i*16 +: 16] = {4'(i), seq[i][11:0]};
      end
      out_ready8 = ($urandom_range(3) != 0);
      fixed_en8 = ($urandom_range(6) == 0);
      fixed_sel8 = 3'($urandom_range(7));
      #1;
      if (out_valid8 && out_ready8) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rnd_dup cyc=%0d got d=%h want no word", cyc, out_data8);
        end else begin
          exp_w = sb.pop_front();
          if (out_data8 !== exp_w || out_sel8 !== exp_w[14:12]) begin
            failures++;
            $display("FAIL rnd_data cyc=%0d got d=%h s=%0d want d=%h s=%0d", cyc, out_data8, out_sel8, exp_w, exp_w[14:12]);
          end
          xfers++;
        end
      end
      checks++;
      if ($countones(in_ready8) > 1 || (in_ready8 & ~in_valid8) != 8'h00) begin
        failures++;
        $display("FAIL rnd_onehot cyc=%0d got rdy=%b valid=%b", cyc, in_ready8, in_valid8);
      end
      if (out_valid8 && !out_ready8) begin
        checks++;
        if (in_ready8 !== 8'h00) begin
          failures++;
          $display("FAIL rnd_stall cyc=%0d got rdy=%b want 00000000", cyc, in_ready8);
        end
      end
      if (!fixed_en8 && (|in_valid8) && (!out_valid8 || out_ready8)) begin
        checks++;
        if (in_ready8 === 8'h00) begin
          failures++;
          $display("FAIL rnd_nogrant cyc=%0d got rdy=0 valid=%b", cyc, in_valid8);
        end
      end
      g = -1;
      for (int i = 0; i < 8; i++) if (in_ready8[i]) g = i;
      if (g >= 0) sb.push_back({4'(g), seq[g][11:0]});
      if (fixed_en8) begin
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
      end else if (g >= 0) begin
        for (int i = 0; i < 8; i++) begin
          if (i == g) wait_cnt[i] = 0;
          else if (pv[i]) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > 7) begin
              failures++;
              $display("FAIL rnd_starve cyc=%0d ch=%0d got wait=%0d want <=7", cyc, i, wait_cnt[i]);
            end
          end
        end
      end
      tick();
      checks++;
      if (out_valid8 !== (sb.size() != 0)) begin
        failures++;
        $display("FAIL rnd_valid cyc=%0d got v=%b want %b", cyc, out_valid8, (sb.size() != 0));
      end
      if (g >= 0) begin
        seq[g]++;
        pv[g] = 1'($urandom_range(1));
      end
      for (int i = 0; i < 8; i++) begin
        if (!pv[i] && i != g) pv[i] = ($urandom_range(2) == 0);
      end
    end
    $display("test_random transfers=%0d new_failures=%0d", xfers, failures - fails_before);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_data8 = '0;
    in_valid8 = '0;
    fixed_en8 = 1'b0;
    fixed_sel8 = '0;
    out_ready8 = 1'b0;
    in_data5 = '0;
    in_valid5 = '0;
    fixed_en5 = 1'b0;
    fixed_sel5 = '0;
    out_ready5 = 1'b0;
    tick();
    tick();
    test_reset();
    test_rr_rotation();
    test_backpressure();
    test_fixed();
    test_back_to_back();
    test_sparse_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
